// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program-load port, branch/jump redirect, and the
// valid/ready instruction stream toward decode.
interface fetch_unit_if #(
  parameter int XLEN       = 32,
  parameter int IMEM_BYTES = 1024
);
  localparam int AW = $clog2(IMEM_BYTES);

  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [7:0]      load_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_ready;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] pc;
  logic            fault;

  modport master (
    output load_en, load_addr, load_data, redirect_valid, redirect_pc, instr_ready,
    input  instr_valid, instr, instr_pc, pc, fault
  );

  modport slave (
    input  load_en, load_addr, load_data, redirect_valid, redirect_pc, instr_ready,
    output instr_valid, instr, instr_pc, pc, fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, byte-addressed instruction memory
// read as one little-endian word per cycle, valid/ready output, sticky fault.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_BYTES = 1024,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic          CLK,
  input  logic          RESET,
  fetch_unit_if.slave   bus
);
  localparam int              W   = XLEN / 8;
  localparam int              AW  = $clog2(IMEM_BYTES);
  localparam logic [XLEN-1:0] W_X = XLEN'(W);

  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] instr_reg, instr_next;
  logic [XLEN-1:0] instr_pc_reg, instr_pc_next;
  logic            valid_reg, valid_next;
  logic            mem_we;
  logic            misaligned;
  logic [XLEN-1:0] fetch_word;

  logic [7:0] mem [IMEM_BYTES];

  assign misaligned = (bus.redirect_pc % W_X) != '0;

  // Each byte lane wraps on its own so a word straddling the top of
  // memory picks up its remaining bytes from address 0 upward.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_lane
      logic [AW-1:0] lane_idx;
      assign lane_idx = pc_reg[AW-1:0] + AW'(gi);
      assign fetch_word[8*gi +: 8] = mem[lane_idx];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    mem_we        = 1'b0;

    case (state_reg)
      ST_FAULT: begin
        valid_next = 1'b0;
      end
      default: begin
        if (bus.redirect_valid && misaligned) begin
          state_next = ST_FAULT;
          valid_next = 1'b0;
        end else begin
          // A load byte still lands when an aligned redirect shares the edge.
          mem_we = bus.load_en;
          if (bus.redirect_valid) begin
            pc_next    = bus.redirect_pc;
            valid_next = 1'b0;
          end else if (bus.load_en) begin
            valid_next = 1'b0;
          end else if (!valid_reg || bus.instr_ready) begin
            instr_next    = fetch_word;
            instr_pc_next = pc_reg;
            valid_next    = 1'b1;
            pc_next       = pc_reg + W_X;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= ST_RUN;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
    end
  end

  // Memory contents survive reset; the loader may fill it while RESET is held.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.instr_valid = valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign bus.pc          = pc_reg;
  assign bus.fault       = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written reset/fault
// sequences, then randomized traffic against a byte-array reference model.
module tb_fetch_unit;
  localparam int MB = 16;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  fetch_unit_if #(.XLEN(32), .IMEM_BYTES(MB)) bus ();

  fetch_unit #(.XLEN(32), .IMEM_BYTES(MB), .RESET_PC(32'h0)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: architectural state as plain variables.
  logic [7:0]  m_mem [MB];
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_valid, m_fault;

  typedef struct {
    bit          le;
    logic [3:0]  la;
    logic [7:0]  ld;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] ei;
    logic [31:0] eipc;
    logic [31:0] epc;
    bit          ef;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(bit le, logic [3:0] la, logic [7:0] ld, bit rv,
                              logic [31:0] rpc, bit rdy, bit ev, logic [31:0] ei,
                              logic [31:0] eipc, logic [31:0] epc, bit ef);
    vec_t v;
    v.le = le; v.la = la; v.ld = ld; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.eipc = eipc; v.epc = epc; v.ef = ef;
    return v;
  endfunction

  function automatic logic [31:0] m_word(logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = m_mem[int'((a + 32'(k)) % 32'(MB))];
    return w;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  // One clock edge of the fetch rules, highest priority first.
  task automatic m_edge();
    if (m_fault) begin
      m_valid = 1'b0;
    end else if (bus.redirect_valid && (bus.redirect_pc % 32'd4) != 0) begin
      m_fault = 1'b1;
      m_valid = 1'b0;
    end else begin
      if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc;
        m_valid = 1'b0;
      end else if (bus.load_en) begin
        m_valid = 1'b0;
      end else if (!(m_valid && !bus.instr_ready)) begin
        m_instr = m_word(m_pc);
        m_ipc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_out(string tag, bit ev, logic [31:0] ei, logic [31:0] eipc,
                         logic [31:0] epc, bit ef, bit all_fields);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(ev));
    chk({tag, ".pc"},    bus.pc,               epc);
    chk({tag, ".fault"}, 32'(bus.fault),       32'(ef));
    if (ev || all_fields) begin
      chk({tag, ".instr"},    bus.instr,    ei);
      chk({tag, ".instr_pc"}, bus.instr_pc, eipc);
    end
    $display("%s: valid=%0b instr=%h instr_pc=%h pc=%h fault=%0b",
             tag, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc, bus.fault);
  endtask

  task automatic drive(bit le, logic [3:0] la, logic [7:0] ld, bit rv,
                       logic [31:0] rpc, bit rdy);
    bus.load_en = le; bus.load_addr = la; bus.load_data = ld;
    bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.instr_ready = rdy;
    m_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
  endtask

  // Called 1 time unit after a posedge: asserts RESET mid-cycle, checks the
  // outputs dropped before the next edge, then releases after that edge.
  task automatic pulse_reset(string tag);
    idle();
    #2;
    RESET = 1'b1;
    m_reset();
    #1;
    chk_out(tag, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  logic [7:0] image [MB];

  initial begin
    logic [31:0] rpc;
    bit le, rv, rdy;

    image = '{8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};

    tbl[0]  = mk(0, 0, 0,     0, 0,     1, 1, 32'h00010008, 32'h00, 32'h04, 0);
    tbl[1]  = mk(0, 0, 0,     0, 0,     1, 1, 32'h00010000, 32'h04, 32'h08, 0);
    tbl[2]  = mk(0, 0, 0,     0, 0,     0, 1, 32'h00010000, 32'h04, 32'h08, 0);
    tbl[3]  = mk(0, 0, 0,     0, 0,     0, 1, 32'h00010000, 32'h04, 32'h08, 0);
    tbl[4]  = mk(0, 0, 0,     0, 0,     0, 1, 32'h00010000, 32'h04, 32'h08, 0);
    tbl[5]  = mk(0, 0, 0,     0, 0,     1, 1, 32'hA1B2C3D4, 32'h08, 32'h0C, 0);
    tbl[6]  = mk(0, 0, 0,     1, 32'h10, 0, 0, 32'h0,       32'h0,  32'h10, 0);
    tbl[7]  = mk(0, 0, 0,     0, 0,     0, 1, 32'h00010008, 32'h10, 32'h14, 0);
    tbl[8]  = mk(0, 0, 0,     1, 32'h0C, 1, 0, 32'h0,       32'h0,  32'h0C, 0);
    tbl[9]  = mk(0, 0, 0,     0, 0,     1, 1, 32'h11223344, 32'h0C, 32'h10, 0);
    tbl[10] = mk(0, 0, 0,     0, 0,     1, 1, 32'h00010008, 32'h10, 32'h14, 0);
    tbl[11] = mk(1, 5, 8'hEE, 0, 0,     1, 0, 32'h0,       32'h0,  32'h14, 0);
    tbl[12] = mk(1, 6, 8'h77, 1, 32'h04, 1, 0, 32'h0,      32'h0,  32'h04, 0);
    tbl[13] = mk(0, 0, 0,     0, 0,     1, 1, 32'h0077EE00, 32'h04, 32'h08, 0);
    tbl[14] = mk(1, 8, 8'h55, 1, 32'h12, 1, 0, 32'h0,      32'h0,  32'h08, 1);

    idle();
    m_reset();
    #1;
    RESET = 1'b1;
    #1;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Program load while RESET is held.
    for (int a = 0; a < MB; a++) begin
      bus.load_en = 1'b1; bus.load_addr = 4'(a); bus.load_data = image[a];
      m_mem[a] = image[a];
      @(posedge CLK);
      #1;
    end
    idle();
    RESET = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].le, tbl[i].la, tbl[i].ld, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].eipc,
              tbl[i].epc, tbl[i].ef, 1'b0);
    end

    // Fault is sticky: redirects and loads are ignored for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'd9, 8'h99, i[0], 32'h0, 1'b1);
      chk_out($sformatf("fault_hold%0d", i), 1'b0, 32'h0, 32'h0, 32'h08, 1'b1, 1'b0);
    end

    pulse_reset("fault_clear");
    drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
    chk_out("resume", 1'b1, 32'h00010008, 32'h0, 32'h04, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 32'h08, 1'b1);
    chk_out("redir8", 1'b0, 32'h0, 32'h0, 32'h08, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
    chk_out("no_write_in_fault", 1'b1, 32'hA1B2C3D4, 32'h08, 32'h0C, 1'b0, 1'b0);

    pulse_reset("async_reset");
    drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
    chk_out("after_async", 1'b1, 32'h00010008, 32'h0, 32'h04, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      le  = ($urandom_range(0, 99) < 15);
      rv  = ($urandom_range(0, 99) < 12);
      rdy = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 9))
        0:       rpc = $urandom & ~32'h3;
        1:       rpc = 32'hFFFF_FFFC;
        2:       rpc = 32'($urandom_range(0, 63)) | 32'($urandom_range(1, 3));
        default: rpc = 32'($urandom_range(0, 15)) * 32'd4;
      endcase
      drive(le, 4'($urandom), 8'($urandom), rv, rpc, rdy);
      chk_out($sformatf("rnd%0d", i), m_valid, m_instr, m_ipc, m_pc, m_fault, 1'b0);
      if (m_fault && $urandom_range(0, 3) == 0) pulse_reset($sformatf("rnd_reset%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the MIPS datapath, replacing the separate program-counter, PC-incrementer and byte-wide instruction-memory trio with one synchronous block. It holds the PC, reads one little-endian instruction word per cycle from an internal byte-addressed memory, and presents it downstream through a valid/ready handshake. Branch/jump redirects, downstream back-pressure, a program-load port and a misalignment fault are supported. It sits between the program loader/testbench and the decode stage.

## Interface
- XLEN, 32: instruction and PC width in bits; multiple of 8, ≥ 16. Instruction size W = XLEN/8 bytes.
- IMEM_BYTES, 1024: instruction-memory depth in bytes; power of two, ≥ W.
- RESET_PC, 0: PC value after reset; must be W-aligned.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  reset; asynchronous, active-high.
- load_en  in  1  write one byte into instruction memory this cycle.
- load_addr  in  log2(IMEM_BYTES)  byte address for load.
- load_data  in  8  byte to write.
- redirect_valid  in  1  take a branch/jump this cycle.
- redirect_pc  in  XLEN  target PC.
- instr_ready  in  1  decode stage accepts instr this cycle.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr  out  XLEN  instruction word.
- instr_pc  out  XLEN  PC of instr.
- pc  out  XLEN  address of the next fetch.
- fault  out  1  sticky misaligned-redirect flag.

## Operation
- Reset values: pc = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0, fault = 0. Memory contents are not reset.
- Fetch word at address A: instr = {mem[A+W-1], …, mem[A+1], mem[A]} (byte A in bits 7:0). Memory index = address mod IMEM_BYTES; byte addresses wrap individually, so a word at IMEM_BYTES−2 takes bytes from the top and bottom of memory.
- Per posedge, the first matching condition wins:
  1. fault = 1: instr_valid ← 0, pc held. Only RESET clears this state.
  2. redirect_valid with redirect_pc not W-aligned: fault ← 1, instr_valid ← 0, pc unchanged.
  3. redirect_valid (aligned): pc ← redirect_pc, instr_valid ← 0. Any un-accepted instr is flushed, even when instr_ready = 0.
  4. load_en: mem[load_addr] ← load_data, instr_valid ← 0, pc held. Fetch is suspended for the cycle.
  5. Stall (instr_valid = 1 and instr_ready = 0): instr, instr_pc, instr_valid and pc all hold.
  6. Advance: instr ← word(pc), instr_pc ← pc, instr_valid ← 1, pc ← pc + W (mod 2^XLEN).
- A handshake completes on a posedge where instr_valid = 1 and instr_ready = 1. In that cycle the unit advances (case 6) in the same edge, giving back-to-back throughput of one instruction per cycle.
- The load byte write (case 4) also happens when redirect_valid is high. The write is suppressed only when fault = 1 or on a misaligned redirect.

## Timing
- Fetch latency is 1 cycle: the word at pc appears on instr after the next posedge.
- After RESET deasserts, the first posedge gives instr_valid = 1 with instr_pc = RESET_PC.
- Redirect penalty is 1 bubble. At redirect edge N, instr_valid = 0 after N. The target instruction is valid after N+1.
- A load-then-fetch of the same address returns the new byte on the next fetch. There is no read-during-write bypass within one edge; load suspends fetch anyway.
- RESET asserted mid-operation immediately forces all outputs to their reset values without waiting for CLK, and discards any in-flight instruction.
- pc is a registered output and always equals the address of the next word to be fetched.

## Test plan
- **Reset/sequencing:** load 0x00010008 at byte 0 and 0x00010000 at byte 4, release RESET, hold instr_ready = 1 → cycle 1 gives instr = 0x00010008 with instr_pc = 0; cycle 2 gives instr = 0x00010000 with instr_pc = 4; pc = 8.
- **Back-pressure:** instr_ready = 0 for 3 cycles while instr_pc = 4 → instr, instr_pc and pc remain stable. Raising ready gives instr_pc = 8 on the next edge.
- **Redirect during stall:** instr_ready = 0, redirect_valid = 1 with redirect_pc = 0x10 → next edge instr_valid = 0 and pc = 0x10; the edge after that gives instr_pc = 0x10.
- **Misaligned redirect:** redirect_pc = 0x12 → fault = 1 and instr_valid stays 0 for 10 cycles. RESET clears fault, and fetch resumes at RESET_PC.
- **Wrap-around (IMEM_BYTES = 16):** redirect to 12, then 16 → the second fetch returns the same word as address 0, with instr_pc = 16.
- **Async reset mid-stream:** pulse RESET between edges while instr_valid = 1 → instr_valid, instr and fault drop to 0 before the next posedge.
